// File: rtl/hosp_pkg.sv
// Shared constants, patient record and admission FSM state encoding for the ER front end.
package hosp_pkg;

  localparam int PRIO_W = 2;
  localparam int ID_W   = 2;
  // One ID per bed, so the room capacity is tied to the ID width.
  localparam int CAP    = 2 ** ID_W;

  typedef struct packed {
    logic [PRIO_W-1:0] prio;
    logic [ID_W-1:0]   id;
  } patient_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ENQ      = 2'd1,
    DEQ      = 2'd2,
    WAIT_OUT = 2'd3
  } adm_state_t;

endpackage

// File: rtl/patient_admission_ctrl_if.sv
// Arrival, discharge, queue-command and treatment signals of the admission controller.
// Optional statistics outputs appear when ADMIT_STATS_EN is defined.
interface patient_admission_ctrl_if;
  import hosp_pkg::*;

  logic                     arr_valid;
  logic                     arr_ready;
  logic [PRIO_W-1:0]        arr_sev;
  logic                     arr_reject;
  logic                     doc_req;
  logic                     discharge;
  logic [ID_W-1:0]          discharge_id;
  logic [PRIO_W+ID_W-1:0]   q_in;
  logic                     q_ende;
  logic                     q_en;
  logic [PRIO_W+ID_W-1:0]   q_out;
  logic [ID_W+1:0]          q_count;
  logic                     treat_valid;
  logic [PRIO_W-1:0]        treat_prio;
  logic [ID_W-1:0]          treat_id;
  logic [ID_W:0]            occupancy;
  logic                     full;
`ifdef ADMIT_STATS_EN
  logic [7:0]               stat_admitted;
  logic [7:0]               stat_rejected;
`endif

  // Environment side: arrivals, doctor, discharge and the priority queue itself.
  modport master (
    output arr_valid, arr_sev, doc_req, discharge, discharge_id, q_out, q_count,
    input  arr_ready, arr_reject, q_in, q_ende, q_en,
    input  treat_valid, treat_prio, treat_id, occupancy, full
`ifdef ADMIT_STATS_EN
    , input stat_admitted, stat_rejected
`endif
  );

  modport slave (
    input  arr_valid, arr_sev, doc_req, discharge, discharge_id, q_out, q_count,
    output arr_ready, arr_reject, q_in, q_ende, q_en,
    output treat_valid, treat_prio, treat_id, occupancy, full
`ifdef ADMIT_STATS_EN
    , output stat_admitted, stat_rejected
`endif
  );

endinterface

// File: rtl/id_pool.sv
// Busy bitmap of patient IDs with lowest-free allocation, release and occupancy count.
module id_pool
  import hosp_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alloc,
  input  logic            free,
  input  logic [ID_W-1:0] free_id,
  output logic [ID_W-1:0] alloc_id,
  output logic [ID_W:0]   occupancy,
  output logic            full
);

  logic [CAP-1:0] busy;
  logic [CAP-1:0] busy_nx;

  // Scanning downward lets the lowest free index overwrite higher ones.
  always_comb begin
    alloc_id = '0;
    for (int i = CAP - 1; i >= 0; i--) begin
      if (!busy[i]) alloc_id = ID_W'(i);
    end
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < CAP; i++) begin
      occupancy = occupancy + (ID_W+1)'(busy[i]);
    end
  end

  assign full = (occupancy == (ID_W+1)'(CAP));

  // Allocation sees the pre-release bitmap; a busy released ID is never the free one picked.
  always_comb begin
    busy_nx = busy;
    if (free && busy[free_id]) busy_nx[free_id] = 1'b0;
    if (alloc && !full)        busy_nx[alloc_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nx;
  end

endmodule

// File: rtl/patient_admission_ctrl.sv
// ER admission front end: admits arrivals, enqueues {prio,id}, dequeues on doctor request.
// Define ADMIT_STATS_EN to add saturating admitted/rejected counters.
module patient_admission_ctrl
  import hosp_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  patient_admission_ctrl_if.slave bus
);

  adm_state_t      state, state_nx;
  logic            doc_pending, doc_pending_nx;
  logic            accept, alloc;
  logic [ID_W-1:0] alloc_id;
  logic [ID_W:0]   occupancy;
  logic            full;
  logic            arr_ready_r;
  logic            arr_reject_r;
  logic            q_en_r, q_ende_r;
  patient_t        q_in_r;
  logic            treat_valid_r;
  patient_t        treat_r;

  id_pool u_id_pool (
    .clk       (clk),
    .rst_n     (rst_n),
    .alloc     (alloc),
    .free      (bus.discharge),
    .free_id   (bus.discharge_id),
    .alloc_id  (alloc_id),
    .occupancy (occupancy),
    .full      (full)
  );

  assign accept = bus.arr_valid && arr_ready_r;
  assign alloc  = accept && !full;

  // A doc_req this cycle counts as pending so the dequeue can start on the next edge.
  always_comb begin
    state_nx       = state;
    doc_pending_nx = doc_pending || bus.doc_req;
    case (state)
      IDLE: begin
        if (alloc)
          state_nx = ENQ;
        else if (!accept && doc_pending_nx && (bus.q_count != '0))
          state_nx = DEQ;
      end
      ENQ:      state_nx = IDLE;
      DEQ:      state_nx = WAIT_OUT;
      WAIT_OUT: begin
        state_nx       = IDLE;
        doc_pending_nx = 1'b0;
      end
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      doc_pending   <= 1'b0;
      arr_ready_r   <= 1'b0;
      arr_reject_r  <= 1'b0;
      q_en_r        <= 1'b0;
      q_ende_r      <= 1'b0;
      q_in_r        <= '0;
      treat_valid_r <= 1'b0;
      treat_r       <= '0;
    end else begin
      state         <= state_nx;
      doc_pending   <= doc_pending_nx;
      arr_ready_r   <= (state_nx == IDLE);
      arr_reject_r  <= accept && full;
      q_en_r        <= (state_nx == ENQ) || (state_nx == DEQ);
      q_ende_r      <= (state_nx == DEQ);
      // q_in doubles as the latched arrival record and holds between enqueues.
      if (alloc) q_in_r <= '{prio: bus.arr_sev, id: alloc_id};
      treat_valid_r <= (state == WAIT_OUT);
      if (state == WAIT_OUT) treat_r <= bus.q_out;
    end
  end

  assign bus.arr_ready   = arr_ready_r;
  assign bus.arr_reject  = arr_reject_r;
  assign bus.q_in        = q_in_r;
  assign bus.q_en        = q_en_r;
  assign bus.q_ende      = q_ende_r;
  assign bus.treat_valid = treat_valid_r;
  assign bus.treat_prio  = treat_r.prio;
  assign bus.treat_id    = treat_r.id;
  assign bus.occupancy   = occupancy;
  assign bus.full        = full;

`ifdef ADMIT_STATS_EN
  logic [7:0] stat_admitted_r;
  logic [7:0] stat_rejected_r;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_admitted_r <= 8'd0;
      stat_rejected_r <= 8'd0;
    end else begin
      if (alloc)          stat_admitted_r <= sat_inc8(stat_admitted_r);
      if (accept && full) stat_rejected_r <= sat_inc8(stat_rejected_r);
    end
  end

  assign bus.stat_admitted = stat_admitted_r;
  assign bus.stat_rejected = stat_rejected_r;
`endif

endmodule
